// File: rtl/fs_accel_quant_mul_seq.sv
// Digit-serial requantization multiplier: |acc| * muler via a registered LUT of
// muler multiples, then rounding right shift, zero-point add and signed saturation.
module fs_accel_quant_mul_seq #(
   parameter int MUL_W   = 32,
   parameter int ACC_W   = 32,
   parameter int DIGIT_W = 4,
   parameter int OUT_W   = 8,
   parameter int SHIFT_W = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cfg_wr,
   input  logic [MUL_W-1:0]   cfg_muler,
   input  logic [SHIFT_W-1:0] cfg_shift,
   input  logic [OUT_W:0]     cfg_zp,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [ACC_W-1:0]   in_acc,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [OUT_W-1:0]   out_data,
   output logic               busy
);

   localparam int NDIG   = ACC_W / DIGIT_W;
   localparam int LUT_N  = 1 << DIGIT_W;
   localparam int LUT_W  = MUL_W + DIGIT_W;
   localparam int PROD_W = MUL_W + ACC_W;
   localparam int P_W    = PROD_W + 2;
   localparam int V_W    = P_W + 1;
   localparam int CNT_W  = $clog2(NDIG + 1);
   localparam logic signed [V_W-1:0] MAX_V = V_W'(2 ** (OUT_W - 1) - 1);
   localparam logic signed [V_W-1:0] MIN_V = -(V_W'(2 ** (OUT_W - 1)));

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_SAT  = 2'd2,
      S_OUT  = 2'd3
   } state_t;

   state_t                    state_q, state_d;
   logic [LUT_W-1:0]          lut_q [LUT_N];
   logic [LUT_W-1:0]          lut_d [LUT_N];
   logic [SHIFT_W-1:0]        shift_q;
   logic signed [OUT_W:0]     zp_q;
   logic                      sign_q;
   logic [ACC_W-1:0]          mag_q;
   logic [ACC_W-1:0]          mag_s;
   logic [PROD_W-1:0]         prod_q;
   logic [LUT_W-1:0]          term_q;
   logic [CNT_W-1:0]          cnt_q;
   logic                      out_valid_q;
   logic [OUT_W-1:0]          out_data_q;
   logic                      cfg_fire_s;
   logic                      acc_fire_s;
   logic signed [P_W-1:0]     p_s;
   logic signed [P_W-1:0]     rnd_s;
   logic signed [P_W-1:0]     r_s;
   logic signed [V_W-1:0]     v_s;
   logic [OUT_W-1:0]          sat_s;

   // A config write in IDLE steals the cycle from the input side.
   assign in_ready   = (state_q == S_IDLE) && !cfg_wr;
   assign cfg_fire_s = (state_q == S_IDLE) && cfg_wr;
   assign acc_fire_s = in_valid && in_ready;
   assign busy       = (state_q != S_IDLE);
   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign mag_s      = in_acc[ACC_W-1] ? (~in_acc + ACC_W'(1)) : in_acc;

   // LUT entry k = k * muler, built from shifted copies of muler
   always_comb begin
      for (int k = 0; k < LUT_N; k++) begin
         lut_d[k] = '0;
         for (int j = 0; j < DIGIT_W; j++) begin
            lut_d[k] = lut_d[k] + ((((k >> j) & 1) != 0) ? (LUT_W'(cfg_muler) << j) : LUT_W'(0));
         end
      end
   end

   // Sign restore, round-half-up shift, zero point, clamp
   always_comb begin
      p_s   = sign_q ? -$signed({2'b00, prod_q}) : $signed({2'b00, prod_q});
      rnd_s = (shift_q == '0) ? P_W'(0)
                              : ($signed({{(P_W-1){1'b0}}, 1'b1}) <<< (shift_q - SHIFT_W'(1)));
      r_s   = (p_s + rnd_s) >>> shift_q;
      v_s   = V_W'(r_s) + V_W'(zp_q);
      if (v_s > MAX_V) begin
         sat_s = MAX_V[OUT_W-1:0];
      end else if (v_s < MIN_V) begin
         sat_s = MIN_V[OUT_W-1:0];
      end else begin
         sat_s = v_s[OUT_W-1:0];
      end
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  state_d = acc_fire_s ? S_MUL : S_IDLE;
         S_MUL:   state_d = (cnt_q == CNT_W'(NDIG)) ? S_SAT : S_MUL;
         S_SAT:   state_d = S_OUT;
         S_OUT:   state_d = out_ready ? S_IDLE : S_OUT;
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath: the LUT read is registered into term_q, so MUL spans NDIG+1 cycles
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < LUT_N; k++) lut_q[k] <= '0;
         shift_q     <= '0;
         zp_q        <= '0;
         sign_q      <= 1'b0;
         mag_q       <= '0;
         prod_q      <= '0;
         term_q      <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         if (cfg_fire_s) begin
            for (int k = 0; k < LUT_N; k++) lut_q[k] <= lut_d[k];
            shift_q <= cfg_shift;
            zp_q    <= $signed(cfg_zp);
         end
         case (state_q)
            S_IDLE: begin
               if (acc_fire_s) begin
                  sign_q <= in_acc[ACC_W-1];
                  mag_q  <= mag_s;
                  prod_q <= '0;
                  term_q <= '0;
                  cnt_q  <= '0;
               end
            end
            S_MUL: begin
               prod_q <= (prod_q << DIGIT_W) + PROD_W'(term_q);
               term_q <= lut_q[mag_q[ACC_W-1 -: DIGIT_W]];
               mag_q  <= mag_q << DIGIT_W;
               cnt_q  <= cnt_q + CNT_W'(1);
            end
            S_SAT: begin
               out_valid_q <= 1'b1;
               out_data_q  <= sat_s;
            end
            S_OUT: begin
               if (out_ready) out_valid_q <= 1'b0;
            end
            default: begin
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fs_accel_quant_mul_seq.sv
// Directed self-checking bench for fs_accel_quant_mul_seq with hand-computed results.
module tb_fs_accel_quant_mul_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cfg_wr = 1'b0;
   logic [31:0] cfg_muler = 32'd0;
   logic [5:0]  cfg_shift = 6'd0;
   logic [8:0]  cfg_zp = 9'd0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_acc = 32'd0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [7:0]  out_data;
   logic        busy;

   int errors = 0;
   int checks = 0;

   fs_accel_quant_mul_seq dut (
      .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_muler(cfg_muler),
      .cfg_shift(cfg_shift), .cfg_zp(cfg_zp), .in_valid(in_valid),
      .in_ready(in_ready), .in_acc(in_acc), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic do_cfg(input logic [31:0] m, input logic [5:0] s, input logic [8:0] z);
      @(negedge clk);
      cfg_wr = 1'b1; cfg_muler = m; cfg_shift = s; cfg_zp = z;
      @(negedge clk);
      cfg_wr = 1'b0;
   endtask

   // Offer one accumulator, return edges from accept to out_valid (no handshake).
   task automatic transact(input logic [31:0] acc, output int lat);
      int n;
      @(negedge clk);
      in_valid = 1'b1; in_acc = acc;
      n = 0;
      while (in_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat = 0;
      while (out_valid !== 1'b1 && lat < 40) begin
         @(posedge clk);
         #1 lat++;
      end
   endtask

   task automatic pop();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      checks++; if (in_ready !== 1'b1)   begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      checks++; if (out_data !== 8'd0)   begin errors++; $display("FAIL reset_out_data got %0d want 0", out_data); end
      checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_basic();
      int lat;
      do_cfg(32'd3, 6'd0, 9'd0);
      transact(32'd5, lat);
      checks++; if (lat !== 10) begin errors++; $display("FAIL basic_latency got %0d want 10", lat); end
      checks++; if (out_data !== 8'd15) begin errors++; $display("FAIL basic_5x3 got %0d want 15", $signed(out_data)); end
      pop();
      transact(32'hFFFF_FFFB, lat);
      checks++; if (out_data !== 8'hF1) begin errors++; $display("FAIL sign_neg5x3 got %0d want -15", $signed(out_data)); end
      pop();
      do_cfg(32'd1, 6'd31, 9'd0);
      transact(32'h8000_0000, lat);
      checks++; if (out_data !== 8'hFF) begin errors++; $display("FAIL sign_min_acc got %0d want -1", $signed(out_data)); end
      pop();
   endtask

   task automatic test_rounding();
      logic [31:0] accs [3];
      logic [7:0]  exps [3];
      int lat;
      accs[0] = 32'd5;          exps[0] = 8'd8;
      accs[1] = 32'hFFFF_FFFB;  exps[1] = 8'hF9;
      accs[2] = 32'd4;          exps[2] = 8'd6;
      do_cfg(32'd3, 6'd1, 9'd0);
      for (int i = 0; i < 3; i++) begin
         transact(accs[i], lat);
         checks++;
         if (out_data !== exps[i]) begin
            errors++; $display("FAIL round_%0d got %0d want %0d", i, $signed(out_data), $signed(exps[i]));
         end
         pop();
      end
   endtask

   task automatic test_saturation();
      int lat;
      do_cfg(32'd1, 6'd0, 9'd0);
      transact(32'd1000, lat);
      checks++; if (out_data !== 8'd127) begin errors++; $display("FAIL sat_pos got %0d want 127", $signed(out_data)); end
      pop();
      transact(32'hFFFF_FC18, lat);
      checks++; if (out_data !== 8'h80) begin errors++; $display("FAIL sat_neg got %0d want -128", $signed(out_data)); end
      pop();
      do_cfg(32'd1, 6'd0, 9'h1FD);
      transact(32'd10, lat);
      checks++; if (out_data !== 8'd7) begin errors++; $display("FAIL zp_neg3 got %0d want 7", $signed(out_data)); end
      pop();
   endtask

   task automatic test_backpressure();
      int lat;
      int bad;
      do_cfg(32'd3, 6'd0, 9'd0);
      transact(32'd2, lat);
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (out_data !== 8'd6 || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL backpressure_hold got %0d bad cycles want 0 (data %0d)", bad, out_data); end
      pop();
      checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL backpressure_release got busy=%b valid=%b ready=%b want 0 0 1", busy, out_valid, in_ready);
      end
   endtask

   task automatic test_cfg_interplay();
      int lat;
      do_cfg(32'd3, 6'd0, 9'd0);
      @(negedge clk);
      in_valid = 1'b1; in_acc = 32'd4;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      cfg_wr = 1'b1; cfg_muler = 32'd7; cfg_shift = 6'd5; cfg_zp = 9'd9;
      @(negedge clk);
      cfg_wr = 1'b0;
      lat = 0;
      while (out_valid !== 1'b1 && lat < 40) begin
         @(posedge clk);
         #1 lat++;
      end
      checks++; if (out_data !== 8'd12) begin errors++; $display("FAIL cfg_in_mul got %0d want 12", $signed(out_data)); end
      pop();
      transact(32'd1, lat);
      checks++; if (out_data !== 8'd3) begin errors++; $display("FAIL cfg_in_mul_kept got %0d want 3", $signed(out_data)); end
      pop();
      @(negedge clk);
      cfg_wr = 1'b1; cfg_muler = 32'd2; cfg_shift = 6'd0; cfg_zp = 9'd0;
      in_valid = 1'b1; in_acc = 32'd9;
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL cfg_valid_ready got %b want 0", in_ready); end
      @(posedge clk);
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cfg_valid_not_accepted got busy=%b want 0", busy); end
      @(negedge clk);
      cfg_wr = 1'b0;
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat = 0;
      while (out_valid !== 1'b1 && lat < 40) begin
         @(posedge clk);
         #1 lat++;
      end
      checks++; if (out_data !== 8'd18) begin errors++; $display("FAIL cfg_valid_newcfg got %0d want 18", $signed(out_data)); end
      pop();
   endtask

   task automatic test_reset_mid();
      int lat;
      do_cfg(32'd5, 6'd0, 9'd4);
      @(negedge clk);
      in_valid = 1'b1; in_acc = 32'd3;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL reset_mid got valid=%b ready=%b busy=%b want 0 1 0", out_valid, in_ready, busy);
      end
      @(negedge clk);
      rst = 1'b0;
      transact(32'd100, lat);
      checks++; if (out_data !== 8'd0) begin errors++; $display("FAIL reset_mid_cleared got %0d want 0", $signed(out_data)); end
      pop();
      do_cfg(32'd0, 6'd0, 9'd5);
      transact(32'd77, lat);
      checks++; if (out_data !== 8'd5) begin errors++; $display("FAIL muler0_zp got %0d want 5", $signed(out_data)); end
      pop();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_rounding();
      test_saturation();
      test_backpressure();
      test_cfg_interplay();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
